// File: rtl/uarch_pkg.sv
// Shared micro-architecture types: decoded instruction, register masks and the
// predicate that identifies ops routed to the single shared mul/ldst/branch unit.
package uarch_pkg;

    localparam int NUM_REGS = 16;

    typedef logic [NUM_REGS-1:0]         hword;
    typedef logic [$clog2(NUM_REGS)-1:0] reg_num;

    typedef struct packed {
        logic alu;
        logic mul;
        logic ldst;
        logic branch;
    } insn_ctrl;

    typedef struct packed {
        insn_ctrl ctrl;
        reg_num   rd;
        reg_num   ra;
        reg_num   rb;
        logic     writes_rd;
        logic     uses_ra;
        logic     uses_rb;
    } insn_decode;

    function automatic logic is_single(input insn_decode dec);
        return dec.ctrl.mul | dec.ctrl.ldst | dec.ctrl.branch;
    endfunction

    function automatic hword reg_onehot(input reg_num r);
        return hword'(1) << r;
    endfunction

endpackage

// File: rtl/core_dispatch_slot_check.sv
// Hazard check for one dispatch slot against the scoreboard and the older
// slots of the same issue group.
module core_dispatch_slot_check
    import uarch_pkg::*;
(
    input  insn_decode dec,
    input  hword       busy_mask,
    input  hword       prior_wmask,
    input  logic       prior_single,
    output logic       ok
);

    hword pending;
    logic src_hazard;
    logic waw_hazard;
    logic unit_hazard;

    always_comb begin
        pending     = busy_mask | prior_wmask;
        src_hazard  = (dec.uses_ra && pending[dec.ra]) || (dec.uses_rb && pending[dec.rb]);
        waw_hazard  = dec.writes_rd && prior_wmask[dec.rd];
        // prior_single already folds in single_busy from the top level
        unit_hazard = is_single(dec) && prior_single;
        ok          = !(src_hazard || waw_hazard || unit_hazard);
    end

endmodule

// File: rtl/core_dispatch_queue.sv
// In-order dispatch queue: accepts whole decode groups, issues up to WIDTH of the
// oldest entries per cycle subject to hazards, and registers the issue outputs.
module core_dispatch_queue
    import uarch_pkg::*;
#(
    parameter int WIDTH = 2,
    parameter int DEPTH = 8
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           flush,
    input  logic       [WIDTH-1:0]         in_valid,
    input  insn_decode [WIDTH-1:0]         in_dec,
    output logic                           in_ready,
    input  hword                           busy_mask,
    input  logic                           single_busy,
    output logic       [WIDTH-1:0]         start_alu,
    output insn_decode [WIDTH-1:0]         dec_alu,
    output logic                           start_single,
    output insn_decode                     dec_single,
    output hword                           issue_wmask,
    output logic [$clog2(WIDTH+1)-1:0]     issue_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int NW = $clog2(WIDTH + 1);

    typedef logic [AW-1:0] ptr_t;
    typedef logic [CW-1:0] cnt_t;
    typedef logic [NW-1:0] num_t;

    insn_decode mem [DEPTH];
    ptr_t       head;
    ptr_t       tail;
    cnt_t       count;

    logic                     enq_fire;
    num_t                     enq_num;
    num_t                     deq_num;
    insn_decode [WIDTH-1:0]   slot_dec;
    hword       [WIDTH-1:0]   prior_wmask;
    logic       [WIDTH-1:0]   prior_single;
    logic       [WIDTH-1:0]   slot_ok;
    logic       [WIDTH-1:0]   issue;
    logic       [WIDTH-1:0]   alu_nxt;
    logic                     single_nxt;
    insn_decode               single_dec_nxt;
    hword                     wmask_nxt;

    // Input handshake: a group transfers on any cycle with in_ready && |in_valid
    // (and no flush). in_ready depends only on occupancy, never on in_valid.
    assign in_ready = (count <= cnt_t'(DEPTH - WIDTH));
    assign enq_fire = in_ready && (|in_valid) && !flush;

    always_comb begin
        enq_num = '0;
        for (int i = 0; i < WIDTH; i++) begin
            enq_num = enq_num + num_t'(in_valid[i]);
        end
    end

    // Slot view of the oldest entries and the accumulated state of older slots.
    always_comb begin
        hword acc_wmask;
        logic acc_single;
        acc_wmask  = '0;
        acc_single = single_busy;
        for (int k = 0; k < WIDTH; k++) begin
            slot_dec[k]     = mem[ptr_t'(head + ptr_t'(k))];
            prior_wmask[k]  = acc_wmask;
            prior_single[k] = acc_single;
            if (slot_dec[k].writes_rd) acc_wmask = acc_wmask | reg_onehot(slot_dec[k].rd);
            acc_single = acc_single | is_single(slot_dec[k]);
        end
    end

    for (genvar k = 0; k < WIDTH; k++) begin : g_slot
        core_dispatch_slot_check u_check (
            .dec          (slot_dec[k]),
            .busy_mask    (busy_mask),
            .prior_wmask  (prior_wmask[k]),
            .prior_single (prior_single[k]),
            .ok           (slot_ok[k])
        );
    end

    // Strict in-order issue: a blocked slot stops every younger slot.
    always_comb begin
        logic chain;
        chain          = 1'b1;
        issue          = '0;
        deq_num        = '0;
        alu_nxt        = '0;
        single_nxt     = 1'b0;
        single_dec_nxt = slot_dec[0];
        wmask_nxt      = '0;
        for (int k = 0; k < WIDTH; k++) begin
            chain    = chain && slot_ok[k] && (cnt_t'(k) < count);
            issue[k] = chain;
            if (chain) begin
                deq_num = deq_num + num_t'(1);
                if (slot_dec[k].ctrl.alu) alu_nxt[k] = 1'b1;
                if (is_single(slot_dec[k])) begin
                    single_nxt     = 1'b1;
                    single_dec_nxt = slot_dec[k];
                end
                if (slot_dec[k].writes_rd) wmask_nxt = wmask_nxt | reg_onehot(slot_dec[k].rd);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head         <= '0;
            tail         <= '0;
            count        <= '0;
            start_alu    <= '0;
            start_single <= 1'b0;
            issue_wmask  <= '0;
            issue_count  <= '0;
        end else if (flush) begin
            head         <= '0;
            tail         <= '0;
            count        <= '0;
            start_alu    <= '0;
            start_single <= 1'b0;
            issue_wmask  <= '0;
            issue_count  <= '0;
        end else begin
            head         <= head + ptr_t'(deq_num);
            if (enq_fire) tail <= tail + ptr_t'(enq_num);
            count        <= count + (enq_fire ? cnt_t'(enq_num) : cnt_t'(0)) - cnt_t'(deq_num);
            start_alu    <= alu_nxt;
            start_single <= single_nxt;
            issue_wmask  <= wmask_nxt;
            issue_count  <= deq_num;
        end
    end

    // Payload only; qualified by the start/valid state above.
    always_ff @(posedge clk) begin
        dec_alu    <= slot_dec;
        dec_single <= single_dec_nxt;
        for (int i = 0; i < WIDTH; i++) begin
            if (enq_fire && in_valid[i]) mem[ptr_t'(tail + ptr_t'(i))] <= in_dec[i];
        end
    end

endmodule

// File: doc/core_dispatch_queue.md
CORE_DISPATCH_QUEUE -- requirements
Module: core_dispatch_queue

Interface
REQ-001 The block SHALL have parameter WIDTH, default 2, giving the issue width (range 2..4).
REQ-002 The block SHALL have parameter DEPTH, default 8, giving the queue entries (power of two, DEPTH >= 2*WIDTH).
REQ-003 The block SHALL have port clk, input, 1, the single clock.
REQ-004 The block SHALL have port rst_n, input, 1, the asynchronous active-low reset.
REQ-005 The block SHALL have port flush, input, 1, which discards all queued and selected instructions.
REQ-006 The block SHALL have port in_valid, input, WIDTH, per-lane valid from decode; lanes are contiguous from lane 0.
REQ-007 The block SHALL have port in_dec, input, WIDTH x insn_decode, the decoded group, lane 0 oldest.
REQ-008 The block SHALL have port in_ready, output, 1, the group-accept signal.
REQ-009 The block SHALL have port busy_mask, input, hword, registers with pending writes from the scoreboard.
REQ-010 The block SHALL have port single_busy, input, 1, meaning the shared mul/ldst/branch path cannot accept this cycle.
REQ-011 The block SHALL have port start_alu, output, WIDTH, per-slot ALU start.
REQ-012 The block SHALL have port dec_alu, output, WIDTH x insn_decode, per-slot ALU instruction.
REQ-013 The block SHALL have ports start_single, output, 1, and dec_single, output, insn_decode, for the shared-unit start and instruction.
REQ-014 The block SHALL have port issue_wmask, output, hword, the destination registers issued this cycle.
REQ-015 The block SHALL have port issue_count, output, clog2(WIDTH+1), the number of instructions issued.

Function
REQ-016 in_ready SHALL be 1 iff free entries (DEPTH - count) >= WIDTH; a group SHALL be accepted whole or not at all.
REQ-017 On in_ready && |in_valid, popcount(in_valid) entries SHALL be written at tail in lane order, with tail wrapping mod DEPTH.
REQ-018 Entries written in cycle N SHALL NOT be dispatch-eligible before cycle N+1.
REQ-019 Each cycle the WIDTH oldest entries SHALL be examined as slots 0..WIDTH-1, and dispatch SHALL be strictly in order: slot k issues only if slots 0..k-1 issue.
REQ-020 Slot k SHALL be blocked if k >= count.
REQ-021 Slot k SHALL be blocked if a used source (ra/uses_ra, rb/uses_rb) is set in busy_mask.
REQ-022 Slot k SHALL be blocked if a used source equals the rd of an earlier writing slot in the same group (RAW).
REQ-023 Slot k SHALL be blocked if its rd equals the rd of an earlier writing slot (WAW).
REQ-024 A mul/ldst/branch slot SHALL be blocked if single_busy is 1 or an earlier slot in the group is a mul/ldst/branch.
REQ-025 The dispatch count d SHALL remove d entries at head, with head wrapping mod DEPTH.
REQ-026 On simultaneous enqueue e and dispatch d, count SHALL become count + e - d.
REQ-027 Outputs SHALL be registered, asserting one cycle after the issue decision: start_alu[k] = issued_k && ctrl.alu; dec_alu[k] = slot k; start_single = any issued single op; dec_single = that slot; issue_wmask = OR of one-hot rd of issued writers; issue_count = d.
REQ-028 flush SHALL take priority over enqueue and dispatch: count, head and tail SHALL go to 0, and start_alu, start_single, issue_wmask and issue_count SHALL be 0 the next cycle.
REQ-029 When count == 0, issue_count SHALL be 0 and all start signals SHALL be 0.

Reset
REQ-030 On rst_n low, count/head/tail, start_alu, start_single, issue_wmask and issue_count SHALL be 0 asynchronously, and in_ready SHALL be 1.
REQ-031 Queue storage, dec_alu and dec_single SHALL need no reset.
REQ-032 Reset asserted mid-operation SHALL discard all entries.

Structure
REQ-033 insn_decode, hword, reg_num and a shared-unit predicate function SHALL live in the uarch package.
REQ-034 The per-slot hazard check SHALL be a sub-module, core_dispatch_slot_check (inputs: slot decode, busy_mask, earlier-slot wmask, earlier-single flag; output: ok).

Verification
REQ-035 The bench SHALL cover: empty queue, enqueue two independent ALU ops (r1=r2+r3, r4=r5+r6) -> next cycle both dispatch, following cycle start_alu=2'b11, issue_wmask=0x0012, issue_count=2.
REQ-036 The bench SHALL cover: group r1=r2+r3, r4=r1+r5 -> slot 1 held, issue_count=1, r4 op issues the cycle after busy_mask clears r1.
REQ-037 The bench SHALL cover: two mul ops adjacent -> one per cycle; with single_busy=1 for 3 cycles -> start_single=0 for those cycles, the ALU op behind the mul is also held.
REQ-038 The bench SHALL cover: fill to count=7 with DEPTH=8, WIDTH=2 -> in_ready=0; one dispatch -> in_ready=1; tail wraps 7->0 and order is preserved.
REQ-039 The bench SHALL cover: flush together with in_valid=2'b11 -> count=0 and no start signal asserted the next cycle.
REQ-040 The bench SHALL cover: rst_n pulsed low with 5 entries queued -> all outputs 0 and in_ready=1 immediately.
